// File: rtl/cosim_step_sched_pkg.sv
// Shared co-simulation types for the Spike lockstep scheduler.
// Contents: scheduler state enum, commit record struct, hart limit,
// and the reg_t/uint32_t/insn_bits_t aliases mirroring the C++ side.
package cosim_step_sched_pkg;

  localparam int COSIM_MAX_HART = 8;

  typedef logic [63:0] reg_t;
  typedef logic [31:0] uint32_t;
  typedef logic [63:0] insn_bits_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    HALT
  } csSchedState_t;

  typedef struct packed {
    reg_t    pc;
    uint32_t ir;
    uint32_t irq;
  } csCmtRec_t;

endpackage

// File: rtl/cosim_cmt_fifo.sv
// Per-hart commit record buffer: circular FIFO of csCmtRec_t.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write a record (ignored when full)
//   pop          drop the head record (ignored when empty)
//   dout         head record (valid when !empty)
//   full, empty  derived from the registered occupancy count
module cosim_cmt_fifo
  import cosim_step_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  csCmtRec_t din,
  input  logic      pop,
  output csCmtRec_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  csCmtRec_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cosim_step_sched.sv
// Spike lockstep sequencer. Buffers per-hart commit records, picks one
// round-robin, asks the DPI shim to step that hart, then compares the
// reference pc/ir against the RTL record; halts on mismatch or timeout.
// Ports:
//   cmt_vld/cmt_rdy/cmt_pc/cmt_ir/cmt_irq   per-hart commit inputs (flat vectors)
//   step_vld/step_rdy/step_pid/step_irq     step request to the shim
//   chg_vld/chg_rdy/chg_pc/chg_ir/chg_trp   change summary from the shim
//   mis_vld/mis_pid/mis_pc                  one-cycle divergence report
//   halted, timeout, step_cnt               status
//   dbg_state                               current scheduler state
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high; a valid, once raised, holds its payload until that edge.
module cosim_step_sched
  import cosim_step_sched_pkg::*;
#(
  parameter int NUM_HART   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_HART-1:0]    cmt_vld,
  output logic [NUM_HART-1:0]    cmt_rdy,
  input  logic [NUM_HART*64-1:0] cmt_pc,
  input  logic [NUM_HART*32-1:0] cmt_ir,
  input  logic [NUM_HART*32-1:0] cmt_irq,
  output logic                   step_vld,
  input  logic                   step_rdy,
  output logic [7:0]             step_pid,
  output logic [31:0]            step_irq,
  input  logic                   chg_vld,
  output logic                   chg_rdy,
  input  reg_t                   chg_pc,
  input  insn_bits_t             chg_ir,
  input  logic                   chg_trp,
  output logic                   mis_vld,
  output logic [7:0]             mis_pid,
  output reg_t                   mis_pc,
  output logic                   halted,
  output logic                   timeout,
  output logic [31:0]            step_cnt,
  output csSchedState_t          dbg_state
);

  localparam int PW = (NUM_HART > 1) ? $clog2(NUM_HART) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  csSchedState_t       state;
  csCmtRec_t           head [NUM_HART];
  logic [NUM_HART-1:0] full;
  logic [NUM_HART-1:0] empty;
  logic [NUM_HART-1:0] pop;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       sel;
  logic [PW-1:0]       sel_q;
  logic                any;
  reg_t                rec_pc;
  uint32_t             rec_ir;
  reg_t                chg_pc_q;
  insn_bits_t          chg_ir_q;
  logic                chg_trp_q;
  logic [TW-1:0]       timer;
  logic                match;
  int                  idx;

  for (genvar h = 0; h < NUM_HART; h++) begin : g_fifo
    csCmtRec_t din;
    assign din = '{pc: cmt_pc[h*64 +: 64], ir: cmt_ir[h*32 +: 32], irq: cmt_irq[h*32 +: 32]};
    cosim_cmt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmt_vld[h]),
      .din   (din),
      .pop   (pop[h]),
      .dout  (head[h]),
      .full  (full[h]),
      .empty (empty[h])
    );
  end

  assign cmt_rdy   = ~full;
  assign dbg_state = state;

  // Scan from the highest offset down so the lowest offset from rr_ptr
  // (the first non-empty FIFO in wrap order) is the last one written.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int i = NUM_HART - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_HART;
      if (!empty[idx]) begin
        sel = PW'(idx);
        any = 1'b1;
      end
    end
  end

  // A trap retires in Spike without a meaningful ir, so only pc must agree.
  assign match = (chg_pc_q == rec_pc) & (chg_trp_q | (chg_ir_q == {32'b0, rec_ir}));

  always_comb begin
    pop = '0;
    for (int h = 0; h < NUM_HART; h++) begin
      pop[h] = (state == CHECK) && match && (sel_q == PW'(h));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel_q     <= '0;
      rec_pc    <= '0;
      rec_ir    <= '0;
      chg_pc_q  <= '0;
      chg_ir_q  <= '0;
      chg_trp_q <= 1'b0;
      timer     <= '0;
      step_vld  <= 1'b0;
      step_pid  <= '0;
      step_irq  <= '0;
      chg_rdy   <= 1'b0;
      mis_vld   <= 1'b0;
      mis_pid   <= '0;
      mis_pc    <= '0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
      step_cnt  <= '0;
    end else begin
      mis_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            sel_q    <= sel;
            rec_pc   <= head[sel].pc;
            rec_ir   <= head[sel].ir;
            step_pid <= 8'(sel);
            step_irq <= head[sel].irq;
            step_vld <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (step_rdy) begin
            step_vld <= 1'b0;
            timer    <= '0;
            chg_rdy  <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving in the expiry cycle still takes the check path.
          if (chg_vld) begin
            chg_pc_q  <= chg_pc;
            chg_ir_q  <= chg_ir;
            chg_trp_q <= chg_trp;
            chg_rdy   <= 1'b0;
            state     <= CHECK;
          end else if (timer == TLAST) begin
            chg_rdy <= 1'b0;
            timeout <= 1'b1;
            mis_vld <= 1'b1;
            mis_pid <= step_pid;
            mis_pc  <= rec_pc;
            halted  <= 1'b1;
            state   <= HALT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (match) begin
            step_cnt <= step_cnt + 1'b1;
            rr_ptr   <= (sel_q == PW'(NUM_HART - 1)) ? '0 : sel_q + 1'b1;
            state    <= IDLE;
          end else begin
            mis_vld <= 1'b1;
            mis_pid <= step_pid;
            mis_pc  <= rec_pc;
            halted  <= 1'b1;
            state   <= HALT;
          end
        end
        HALT:    ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cosim_step_sched.sv
module tb_cosim_step_sched;
  import cosim_step_sched_pkg::*;

  localparam int NH = 4;
  localparam int FD = 8;
  localparam int TO = 1023;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NH-1:0]    cmt_vld;
  logic [NH-1:0]    cmt_rdy;
  logic [NH*64-1:0] cmt_pc;
  logic [NH*32-1:0] cmt_ir;
  logic [NH*32-1:0] cmt_irq;
  logic             step_vld;
  logic             step_rdy;
  logic [7:0]       step_pid;
  logic [31:0]      step_irq;
  logic             chg_vld;
  logic             chg_rdy;
  logic [63:0]      chg_pc;
  logic [63:0]      chg_ir;
  logic             chg_trp;
  logic             mis_vld;
  logic [7:0]       mis_pid;
  logic [63:0]      mis_pc;
  logic             halted;
  logic             timeout;
  logic [31:0]      step_cnt;
  csSchedState_t    dbg_state;

  cosim_step_sched #(.NUM_HART(NH), .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmt_vld   (cmt_vld),
    .cmt_rdy   (cmt_rdy),
    .cmt_pc    (cmt_pc),
    .cmt_ir    (cmt_ir),
    .cmt_irq   (cmt_irq),
    .step_vld  (step_vld),
    .step_rdy  (step_rdy),
    .step_pid  (step_pid),
    .step_irq  (step_irq),
    .chg_vld   (chg_vld),
    .chg_rdy   (chg_rdy),
    .chg_pc    (chg_pc),
    .chg_ir    (chg_ir),
    .chg_trp   (chg_trp),
    .mis_vld   (mis_vld),
    .mis_pid   (mis_pid),
    .mis_pc    (mis_pc),
    .halted    (halted),
    .timeout   (timeout),
    .step_cnt  (step_cnt),
    .dbg_state (dbg_state)
  );

  // checking
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard: expected step order and the committed records {pid, pc, ir, irq}
  logic [7:0]   exp_q[$];
  logic [135:0] rec_q[$];

  // shim controls
  bit shim_rdy_en = 1'b1;
  int shim_lat = 0;          // negative: never answer
  bit shim_bad = 1'b0;       // return a wrong ir
  bit shim_trp = 1'b0;       // return a wrong ir flagged as a trap
  bit shim_clear = 1'b0;
  int take_cnt = 0;
  int take_cyc[$];
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  int          mis_seen = 0;
  int          wait_cyc = 0;
  int          vld_cyc = 0;
  logic [7:0]  mis_pid_seen = '0;
  logic [63:0] mis_pc_seen = '0;
  logic        halted_at_mis = 1'b0;

  always @(negedge clk) begin
    if (chg_rdy) wait_cyc <= wait_cyc + 1;
    if (step_vld) vld_cyc <= vld_cyc + 1;
    if (mis_vld) begin
      mis_seen      <= mis_seen + 1;
      mis_pid_seen  <= mis_pid;
      mis_pc_seen   <= mis_pc;
      halted_at_mis <= halted;
    end
  end

  // shim model: answers each accepted step with the bench's own record
  initial begin : shim
    logic [135:0] r;
    int pend;
    int wcnt;
    bit found;
    pend = 0;
    wcnt = 0;
    r = '0;
    step_rdy = 1'b0;
    chg_vld = 1'b0;
    chg_pc = '0;
    chg_ir = '0;
    chg_trp = 1'b0;
    forever begin
      @(negedge clk);
      chg_vld = 1'b0;
      if (shim_clear) begin
        pend = 0;
      end else if (pend != 0) begin
        if (wcnt == shim_lat) begin
          chg_vld = 1'b1;
          chg_pc  = r[127:64];
          chg_ir  = {32'b0, (shim_bad || shim_trp) ? 32'h0010_0093 : r[63:32]};
          chg_trp = shim_trp;
          pend = 0;
        end
        wcnt++;
      end
      step_rdy = shim_rdy_en;
      if (!shim_clear && pend == 0 && step_vld && step_rdy) begin
        found = 1'b0;
        for (int i = 0; i < rec_q.size(); i++) begin
          if (!found && rec_q[i][135:128] == step_pid) begin
            r = rec_q[i];
            rec_q.delete(i);
            found = 1'b1;
          end
        end
        check("shim_rec_found", 64'(found), 64'd1);
        if (exp_q.size() == 0) check("step_extra", 64'(step_pid), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("step_pid_order", 64'(step_pid), 64'(exp_q.pop_front()));
        if (found) check("step_irq", 64'(step_irq), 64'(r[31:0]));
        take_cyc.push_back(cyc);
        take_cnt++;
        pend = 1;
        wcnt = 0;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    shim_clear = 1'b1;
    cmt_vld = '0;
    exp_q.delete();
    rec_q.delete();
    take_cyc.delete();
    repeat (3) @(negedge clk);
    shim_clear = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic commit_set(input int h, input logic [63:0] pc, input logic [31:0] ir,
                            input logic [31:0] irq, input bit expect_step);
    cmt_vld[h] = 1'b1;
    cmt_pc[h*64 +: 64] = pc;
    cmt_ir[h*32 +: 32] = ir;
    cmt_irq[h*32 +: 32] = irq;
    rec_q.push_back({8'(h), pc, ir, irq});
    if (expect_step) exp_q.push_back(8'(h));
  endtask

  task automatic commit_go();
    @(posedge clk);
    #1;
    cmt_vld = '0;
  endtask

  task automatic commit1(input int h, input logic [63:0] pc, input logic [31:0] ir,
                         input logic [31:0] irq, input bit expect_step);
    int n;
    n = 0;
    while (!cmt_rdy[h] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("cmt_rdy_wait", 64'(cmt_rdy[h]), 64'd1);
    commit_set(h, pc, ir, irq, expect_step);
    commit_go();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_q.size() == 0 && dbg_state == IDLE)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) check("idle_reached", {62'b0, exp_q.size() == 0, dbg_state == IDLE}, 64'd3);
  endtask

  task automatic wait_mis(input int m0, input int budget);
    int n;
    n = 0;
    while (n < budget && mis_seen == m0) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) check("mis_reached", 64'(mis_seen - m0), 64'd1);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int m0;
    int w0;
    int v0;
    logic [31:0] irq;
    cmt_vld = '0;
    cmt_pc = '0;
    cmt_ir = '0;
    cmt_irq = '0;

    // reset state
    do_reset();
    check("rst_cmt_rdy", 64'(cmt_rdy), 64'hF);
    check("rst_step_vld", 64'(step_vld), 64'd0);
    check("rst_chg_rdy", 64'(chg_rdy), 64'd0);
    check("rst_mis_vld", 64'(mis_vld), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_step_pid", 64'(step_pid), 64'd0);
    check("rst_step_irq", 64'(step_irq), 64'd0);
    check("rst_mis_pid", 64'(mis_pid), 64'd0);
    check("rst_mis_pc", mis_pc, 64'd0);
    check("rst_step_cnt", 64'(step_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // single match, then a trapping step with a wrong ir
    m0 = mis_seen;
    irq = $urandom;
    commit_set(0, 64'h8000_0000, 32'h0000_0013, irq, 1'b1);
    commit_go();
    check("t1_vld_early", 64'(step_vld), 64'd0);
    @(posedge clk);
    #1;
    check("t1_vld_lat", 64'(step_vld), 64'd1);
    check("t1_pid", 64'(step_pid), 64'd0);
    check("t1_irq", 64'(step_irq), 64'(irq));
    wait_idle(50);
    check("t1_step_cnt", 64'(step_cnt), 64'd1);
    check("t1_state", 64'(dbg_state), 64'(IDLE));
    check("t1_no_mis", 64'(mis_seen - m0), 64'd0);
    shim_trp = 1'b1;
    commit1(1, 64'h8000_0004, 32'h0000_0013, 32'h0, 1'b1);
    wait_idle(50);
    shim_trp = 1'b0;
    check("t1_trap_cnt", 64'(step_cnt), 64'd2);
    check("t1_trap_no_mis", 64'(mis_seen - m0), 64'd0);

    // round-robin across all harts
    do_reset();
    m0 = mis_seen;
    for (int h = 0; h < NH; h++) commit_set(h, 64'h8000_1000 + 64'(h * 16), $urandom, $urandom, 1'b1);
    commit_go();
    commit_set(0, 64'h8000_1100, $urandom, $urandom, 1'b1);
    commit_go();
    wait_idle(100);
    check("t2_step_cnt", 64'(step_cnt), 64'd5);
    check("t2_takes", 64'(take_cyc.size()), 64'd5);
    for (int i = 1; i < take_cyc.size(); i++) check("t2_turnaround", 64'(take_cyc[i] - take_cyc[i-1]), 64'd4);
    check("t2_no_mis", 64'(mis_seen - m0), 64'd0);

    // mismatch
    do_reset();
    m0 = mis_seen;
    shim_bad = 1'b1;
    commit1(2, 64'h8000_2000, 32'h0000_0013, $urandom, 1'b1);
    wait_mis(m0, 50);
    shim_bad = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t3_mis_once", 64'(mis_seen - m0), 64'd1);
    check("t3_mis_pid", 64'(mis_pid_seen), 64'd2);
    check("t3_mis_pc", mis_pc_seen, 64'h8000_2000);
    check("t3_halt_with_mis", 64'(halted_at_mis), 64'd1);
    check("t3_halted", 64'(halted), 64'd1);
    check("t3_timeout", 64'(timeout), 64'd0);
    check("t3_state", 64'(dbg_state), 64'(HALT));
    check("t3_step_cnt", 64'(step_cnt), 64'd0);
    v0 = vld_cyc;
    commit1(0, 64'h8000_2100, 32'h0000_0013, 32'h0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("t3_no_step", 64'(vld_cyc - v0), 64'd0);

    // timeout
    do_reset();
    m0 = mis_seen;
    shim_lat = -1;
    w0 = wait_cyc;
    commit1(1, 64'h8000_3000, $urandom, $urandom, 1'b1);
    wait_mis(m0, 1200);
    check("t4_wait_cycles", 64'(wait_cyc - w0), 64'(TO));
    check("t4_timeout", 64'(timeout), 64'd1);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_mis_pid", 64'(mis_pid_seen), 64'd1);
    check("t4_mis_pc", mis_pc_seen, 64'h8000_3000);
    check("t4_step_cnt", 64'(step_cnt), 64'd0);

    // response in the expiry cycle wins
    do_reset();
    m0 = mis_seen;
    shim_lat = TO - 1;
    w0 = wait_cyc;
    commit1(1, 64'h8000_3100, $urandom, $urandom, 1'b1);
    wait_idle(1200);
    check("t4v_wait_cycles", 64'(wait_cyc - w0), 64'(TO));
    check("t4v_timeout", 64'(timeout), 64'd0);
    check("t4v_step_cnt", 64'(step_cnt), 64'd1);
    check("t4v_no_mis", 64'(mis_seen - m0), 64'd0);

    // backpressure and pointer wrap
    do_reset();
    m0 = mis_seen;
    shim_lat = 0;
    shim_rdy_en = 1'b0;
    for (int i = 0; i < 8; i++) commit1(1, 64'h8000_4000 + 64'(i * 4), $urandom, $urandom, 1'b1);
    check("t5_full", 64'(cmt_rdy), 64'hD);
    check("t5_pending", 64'(step_vld), 64'd1);
    check("t5_pending_pid", 64'(step_pid), 64'd1);
    shim_rdy_en = 1'b1;
    for (int i = 8; i < 16; i++) commit1(1, 64'h8000_4000 + 64'(i * 4), $urandom, $urandom, 1'b1);
    wait_idle(300);
    check("t5_step_cnt", 64'(step_cnt), 64'd16);
    check("t5_no_mis", 64'(mis_seen - m0), 64'd0);
    check("t5_drained", 64'(cmt_rdy), 64'hF);

    // reset during WAIT
    do_reset();
    shim_lat = -1;
    commit1(3, 64'h8000_5000, $urandom, $urandom, 1'b1);
    w0 = 0;
    while (!chg_rdy && w0 < 20) begin
      @(posedge clk);
      #1;
      w0++;
    end
    check("t6_in_wait", 64'(dbg_state), 64'(WAIT));
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_step_vld", 64'(step_vld), 64'd0);
    check("t6_rst_chg_rdy", 64'(chg_rdy), 64'd0);
    check("t6_rst_state", 64'(dbg_state), 64'(IDLE));
    check("t6_rst_step_pid", 64'(step_pid), 64'd0);
    check("t6_rst_cmt_rdy", 64'(cmt_rdy), 64'hF);
    do_reset();
    shim_lat = 0;
    m0 = mis_seen;
    v0 = vld_cyc;
    repeat (10) @(posedge clk);
    #1;
    check("t6_fifo_empty", 64'(vld_cyc - v0), 64'd0);
    commit1(0, 64'h8000_6000, $urandom, $urandom, 1'b1);
    wait_idle(50);
    check("t6_step_cnt", 64'(step_cnt), 64'd1);
    check("t6_no_mis", 64'(mis_seen - m0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
